// File: rtl/memstage.sv
`default_nettype none
// ============================================================================
// Module   : memstage
// Purpose  : Pipeline memory stage. Passes ALU results through in one cycle and
//            performs aligned LOAD/STORE accesses on a req/gnt/rvalid data bus
//            with byte lanes, load extension, misalignment and timeout faults.
// Revision : 1.0 - initial release
// ============================================================================
// instruction_i / instruction_o layout: [14:12] funct3, [11:7] rd, [6:0] opcode
module memstage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [14:0] instruction_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [14:0] instruction_o,
  output logic [31:0] data_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic [6:0]  C_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  C_OPC_STORE = 7'b0100011;
  localparam logic [1:0]  C_SZ_BYTE   = 2'd0;
  localparam logic [1:0]  C_SZ_HALF   = 2'd1;
  localparam logic [1:0]  C_SZ_WORD   = 2'd2;
  localparam logic [31:0] C_TMO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_cnt, w_cnt_n;
  logic [14:0] r_instr, w_instr_n;
  logic [31:0] r_addr, w_addr_n;
  logic [3:0]  r_be, w_be_n;
  logic [31:0] r_wdata, w_wdata_n;
  logic        r_we, w_we_n;
  logic [1:0]  r_size, w_size_n;
  logic        r_valid, w_valid_n;
  logic        r_mis, w_mis_n;
  logic        r_err, w_err_n;
  logic [31:0] r_data, w_data_n;

  logic        w_is_ld, w_is_st;
  logic [2:0]  w_f3;
  logic [1:0]  w_size;
  logic        w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rsh;
  logic [31:0] w_ld_data;
  logic        w_tmo;

  assign w_f3    = instruction_i[14:12];
  assign w_is_ld = (instruction_i[6:0] == C_OPC_LOAD);
  assign w_is_st = (instruction_i[6:0] == C_OPC_STORE);

  // Decode access size of the incoming instruction; undefined funct3 means word.
  always_comb begin
    w_size = C_SZ_WORD;
    if (w_is_ld) begin
      case (w_f3)
        3'b000, 3'b100: w_size = C_SZ_BYTE;
        3'b001, 3'b101: w_size = C_SZ_HALF;
        default:        w_size = C_SZ_WORD;
      endcase
    end else if (w_is_st) begin
      case (w_f3)
        3'b000:  w_size = C_SZ_BYTE;
        3'b001:  w_size = C_SZ_HALF;
        default: w_size = C_SZ_WORD;
      endcase
    end
  end

  // Alignment check, byte enables and lane-replicated store data for a new access.
  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = rs2_data_i;
    case (w_size)
      C_SZ_BYTE: begin
        w_be    = 4'b0001 << alu_result_i[1:0];
        w_wdata = {4{rs2_data_i[7:0]}};
      end
      C_SZ_HALF: begin
        w_misal = alu_result_i[0];
        w_be    = 4'b0011 << alu_result_i[1:0];
        w_wdata = {2{rs2_data_i[15:0]}};
      end
      default: begin
        w_misal = (alu_result_i[1:0] != 2'b00);
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend (funct3[2] = unsigned).
  assign w_rsh = dmem_rdata_i >> {r_addr[1:0], 3'b000};
  always_comb begin
    w_ld_data = dmem_rdata_i;
    case (r_size)
      C_SZ_BYTE: w_ld_data = r_instr[14] ? {24'd0, w_rsh[7:0]}
                                         : {{24{w_rsh[7]}}, w_rsh[7:0]};
      C_SZ_HALF: w_ld_data = r_instr[14] ? {16'd0, w_rsh[15:0]}
                                         : {{16{w_rsh[15]}}, w_rsh[15:0]};
      default:   w_ld_data = dmem_rdata_i;
    endcase
  end

  assign w_tmo = (r_cnt == C_TMO_LAST);

  // Next-state and next-output logic; completion takes priority over timeout.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_instr_n = r_instr;
    w_addr_n  = r_addr;
    w_be_n    = r_be;
    w_wdata_n = r_wdata;
    w_we_n    = r_we;
    w_size_n  = r_size;
    w_valid_n = 1'b0;
    w_mis_n   = 1'b0;
    w_err_n   = 1'b0;
    w_data_n  = r_data;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_instr_n = instruction_i;
          if (!(w_is_ld || w_is_st)) begin
            w_valid_n = 1'b1;
            w_data_n  = alu_result_i;
          end else if (w_misal) begin
            w_valid_n = 1'b1;
            w_mis_n   = 1'b1;
            w_data_n  = 32'd0;
          end else begin
            w_addr_n  = alu_result_i;
            w_be_n    = w_be;
            w_wdata_n = w_wdata;
            w_we_n    = w_is_st;
            w_size_n  = w_size;
            w_cnt_n   = 32'd0;
            w_state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_cnt_n = r_cnt + 32'd1;
        if (dmem_gnt_i && r_we) begin
          w_valid_n = 1'b1;
          w_data_n  = 32'd0;
          w_state_n = S_IDLE;
        end else if (dmem_gnt_i && dmem_rvalid_i) begin
          w_valid_n = 1'b1;
          w_data_n  = w_ld_data;
          w_state_n = S_IDLE;
        end else if (w_tmo) begin
          w_valid_n = 1'b1;
          w_err_n   = 1'b1;
          w_data_n  = 32'd0;
          w_state_n = S_IDLE;
        end else if (dmem_gnt_i) begin
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_n = r_cnt + 32'd1;
        if (dmem_rvalid_i) begin
          w_valid_n = 1'b1;
          w_data_n  = w_ld_data;
          w_state_n = S_IDLE;
        end else if (w_tmo) begin
          w_valid_n = 1'b1;
          w_err_n   = 1'b1;
          w_data_n  = 32'd0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 32'd0;
      r_instr <= 15'd0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_size  <= C_SZ_WORD;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_instr <= w_instr_n;
      r_addr  <= w_addr_n;
      r_be    <= w_be_n;
      r_wdata <= w_wdata_n;
      r_we    <= w_we_n;
      r_size  <= w_size_n;
      r_valid <= w_valid_n;
      r_mis   <= w_mis_n;
      r_err   <= w_err_n;
      r_data  <= w_data_n;
    end
  end

  assign stall_o       = (r_state != S_IDLE);
  assign dmem_req_o    = (r_state == S_REQ);
  assign dmem_we_o     = r_we && (r_state == S_REQ);
  assign dmem_addr_o   = {r_addr[31:2], 2'b00};
  assign dmem_be_o     = r_be;
  assign dmem_wdata_o  = r_wdata;
  assign valid_o       = r_valid;
  assign instruction_o = r_instr;
  assign data_o        = r_data;
  assign misaligned_o  = r_mis;
  assign bus_err_o     = r_err;

endmodule
`default_nettype wire

// File: doc/memstage.md
MEMSTAGE -- requirements
Module: memstage

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the maximum cycles an access waits in REQ+WAIT before being aborted.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-low; asserted when 0.
REQ-004 valid_i  in  1  instruction_i/alu_result_i/rs2_data_i are valid this cycle.
REQ-005 instruction_i  in  instruction_t  decoded instruction (opcode, rd, funct3).
REQ-006 alu_result_i  in  32  effective address (LOAD/STORE) or result (all other opcodes).
REQ-007 rs2_data_i  in  32  store data.
REQ-008 stall_o  out  1  upstream SHALL hold its outputs while 1.
REQ-009 dmem_req_o, dmem_we_o  out  1 each  memory request and write enable.
REQ-010 dmem_addr_o  out  32  word-aligned address; dmem_be_o  out  4  byte enables; dmem_wdata_o  out  32  lane-aligned store data.
REQ-011 dmem_gnt_i, dmem_rvalid_i  in  1 each  request accepted, read data valid; dmem_rdata_i  in  32  read data.
REQ-012 valid_o  out  1; instruction_o  out  instruction_t; data_o  out  32  result to the writeback stage.
REQ-013 misaligned_o, bus_err_o  out  1 each  single-cycle fault pulses, aligned with valid_o.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT; stall_o SHALL equal (state != IDLE).
REQ-015 In IDLE with valid_i=1, the instruction SHALL be accepted; with valid_i=0, valid_o SHALL be 0 next cycle.
REQ-016 Non-memory opcode accepted: next cycle valid_o=1, data_o=alu_result_i, instruction_o=instruction_i, state stays IDLE (1-cycle latency).
REQ-017 LOAD/STORE accepted and aligned: instruction, address, funct3 and store data SHALL be registered and state SHALL go to REQ.
REQ-018 Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
REQ-019 Misaligned access: no dmem request; next cycle valid_o=1, misaligned_o=1, data_o=0, state IDLE.
REQ-020 In REQ: dmem_req_o=1, dmem_addr_o={addr[31:2],2'b00}, dmem_we_o=1 for STORE and 0 for LOAD; all held stable until dmem_gnt_i=1.
REQ-021 Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; for loads, dmem_be_o SHALL show the same pattern.
REQ-022 dmem_wdata_o SHALL be rs2_data_i[7:0] or [15:0] replicated across lanes for SB/SH, and rs2_data_i for SW.
REQ-023 STORE with dmem_gnt_i=1: next cycle valid_o=1, data_o=0, state IDLE.
REQ-024 LOAD with dmem_gnt_i=1 and dmem_rvalid_i=0: go to WAIT; with both 1 in the same cycle: complete as in REQ-025.
REQ-025 LOAD completion on dmem_rvalid_i=1: next cycle valid_o=1, state IDLE, data_o = lane selected by addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes the word unchanged.
REQ-026 Undefined funct3 values SHALL be treated as a word access.
REQ-027 dmem_rvalid_i SHALL be ignored in IDLE, and in REQ for stores.
REQ-028 A 32-bit cycle counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT.
REQ-029 Counter reaching TIMEOUT-1 without completion: abort; next cycle valid_o=1, bus_err_o=1, data_o=0, dmem_req_o=0, state IDLE.
REQ-030 valid_o, misaligned_o and bus_err_o SHALL be 1 for exactly one cycle per completed instruction; otherwise 0.

Reset
REQ-031 rst_i=0 at a clock edge SHALL force state IDLE, valid_o=0, misaligned_o=0, bus_err_o=0, data_o=0, counter=0, stall_o=0 and dmem_req_o=0 from the next cycle.
REQ-032 Reset during REQ or WAIT SHALL abandon the access with no valid_o; a later dmem_rvalid_i SHALL be ignored.

Verification
REQ-033 ALU op, alu_result_i=0x1234 -> 1 cycle later valid_o=1, data_o=0x1234, stall_o never 1.
REQ-034 LB at addr 0x103, gnt after 2 cycles, rdata 0x80AABBCC one cycle later -> be=0001<<3 (4'b1000), addr 0x100, data_o=0xFFFFFF80; LBU of the same -> 0x00000080.
REQ-035 SH at addr 0x202, rs2=0xDEADBEEF, gnt immediately -> be=4'b1100, wdata=0xBEEFBEEF, we=1, valid_o 1 cycle after gnt, data_o=0.
REQ-036 LW at 0x101 -> no dmem_req_o; next cycle misaligned_o=1, valid_o=1.
REQ-037 LW with gnt and rvalid never asserted, TIMEOUT=8 -> bus_err_o=1 and valid_o=1 exactly 8 cycles after REQ entry; stall_o drops the following cycle.
REQ-038 LW granted, rst_i=0 in WAIT, rvalid arrives after reset -> valid_o stays 0, state IDLE.
